// File: rtl/battleship_game_fsm.sv
// battleship_game_fsm
//
// Top-level game sequencer for the battleship VGA design. It walks the player
// through ship placement one ship length at a time, then hands off to the PC
// board generator. After that it alternates player and PC turns and tracks
// the unsunk cells on both boards to declare a win or a loss.
//
// Optional feature macro: TURN_TIMER_EN
//   defined   -> a per-turn counter forfeits the player's turn after
//                TURN_CYCLES clocks without a resolved shot (turn_timeout pulse)
//   undefined -> no counter is built, turn_timeout is tied low and the player
//                turn waits indefinitely for shot_valid
//
// Parameters:
//   TURN_CYCLES  player-turn timeout length in clk cycles
//   MAX_SHIPS    largest ship length / maximum ship count (5x5 board)
//
// Ports:
//   clk                     system clock, rising edge
//   rst                     synchronous active-low reset
//   start_btn               level, rising edge starts / restarts the game
//   ships_to_place [2:0]    ship count, sampled on the start edge in IDLE
//   confirm_placement       level, rising edge = one ship placed
//   placement_error         level, blocks confirm edges while high
//   pc_place_done           pulse, PC board generation finished
//   shot_valid              pulse, current side's shot is resolved
//   shot_hit                qualifies shot_valid (1 = hit)
//   colocation_ships_State  high in PLACE
//   initial_ships_count     length of the ship currently being placed
//   pc_place_req            high in PC_PLACE
//   player_turn             high in PLAYER_TURN
//   pc_turn                 high in PC_TURN
//   game_won                high in WIN
//   game_lost               high in LOSE
//   turn_timeout            one-cycle pulse when the player forfeits a turn
//   player_cells_left [3:0] unsunk cells on the player board
//   pc_cells_left [3:0]     unsunk cells on the PC board

module battleship_game_fsm #(
  parameter int TURN_CYCLES = 750_000_000,
  parameter int MAX_SHIPS   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic [2:0] ships_to_place,
  input  logic       confirm_placement,
  input  logic       placement_error,
  input  logic       pc_place_done,
  input  logic       shot_valid,
  input  logic       shot_hit,
  output logic       colocation_ships_State,
  output logic [2:0] initial_ships_count,
  output logic       pc_place_req,
  output logic       player_turn,
  output logic       pc_turn,
  output logic       game_won,
  output logic       game_lost,
  output logic       turn_timeout,
  output logic [3:0] player_cells_left,
  output logic [3:0] pc_cells_left
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLACE,
    S_PC_PLACE,
    S_PLAYER_TURN,
    S_PC_TURN,
    S_WIN,
    S_LOSE
  } state_t;

  localparam logic [2:0] MAX_N = 3'(MAX_SHIPS);

  state_t     r_state;
  state_t     w_nextState;
  logic       r_startPrev;
  logic       r_confirmPrev;
  logic [2:0] r_shipCount;
  logic [2:0] w_shipCount;
  logic [3:0] r_playerCells;
  logic [3:0] w_playerCells;
  logic [3:0] r_pcCells;
  logic [3:0] w_pcCells;
  logic [2:0] w_shipsClamped;
  logic [3:0] w_totalCells;
  logic       w_startEdge;
  logic       w_confirmEdge;

`ifdef TURN_TIMER_EN
  // Guard against a zero-width counter for degenerate TURN_CYCLES values.
  localparam int CW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CW-1:0] TERM_COUNT = CW'(TURN_CYCLES - 1);

  logic [CW-1:0] r_turnCnt;
  logic [CW-1:0] w_turnCnt;
  logic          r_turnTimeout;
  logic          w_turnTimeout;
`endif

  assign w_startEdge   = start_btn & ~r_startPrev;
  assign w_confirmEdge = confirm_placement & ~r_confirmPrev;

  // Clamp the requested ship count into 1..MAX_SHIPS and look up the total
  // number of occupied cells n(n+1)/2 (ships of length n, n-1, ..., 1).
  always_comb begin
    w_shipsClamped = ships_to_place;
    if (ships_to_place == 3'd0) begin
      w_shipsClamped = 3'd1;
    end else if (ships_to_place > MAX_N) begin
      w_shipsClamped = MAX_N;
    end

    w_totalCells = 4'd15;
    case (w_shipsClamped)
      3'd1:    w_totalCells = 4'd1;
      3'd2:    w_totalCells = 4'd3;
      3'd3:    w_totalCells = 4'd6;
      3'd4:    w_totalCells = 4'd10;
      default: w_totalCells = 4'd15;
    endcase
  end

  // Next-state and datapath update. Shots only count in the turn states; a
  // hit against an already-empty board is treated like a miss so the counts
  // can never wrap.
  always_comb begin
    w_nextState   = r_state;
    w_shipCount   = r_shipCount;
    w_playerCells = r_playerCells;
    w_pcCells     = r_pcCells;
`ifdef TURN_TIMER_EN
    w_turnTimeout = 1'b0;
    // Counter runs only while in PLAYER_TURN; any other state holds it at 0,
    // so every entry into PLAYER_TURN starts from a cleared count.
    w_turnCnt     = (r_state == S_PLAYER_TURN) ? r_turnCnt + CW'(1) : '0;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_startEdge) begin
          w_shipCount   = w_shipsClamped;
          w_playerCells = w_totalCells;
          w_pcCells     = w_totalCells;
          w_nextState   = S_PLACE;
        end
      end

      S_PLACE: begin
        if (w_confirmEdge && !placement_error) begin
          if (r_shipCount > 3'd1) begin
            w_shipCount = r_shipCount - 3'd1;
          end else begin
            w_shipCount = 3'd0;
            w_nextState = S_PC_PLACE;
          end
        end
      end

      S_PC_PLACE: begin
        if (pc_place_done) begin
          w_nextState = S_PLAYER_TURN;
        end
      end

      S_PLAYER_TURN: begin
        if (shot_valid) begin
          if (shot_hit && (r_pcCells != 4'd0)) begin
            w_pcCells   = r_pcCells - 4'd1;
            w_nextState = (r_pcCells == 4'd1) ? S_WIN : S_PC_TURN;
          end else begin
            w_nextState = S_PC_TURN;
          end
        end
`ifdef TURN_TIMER_EN
        else if (r_turnCnt == TERM_COUNT) begin
          w_nextState   = S_PC_TURN;
          w_turnTimeout = 1'b1;
        end
`endif
      end

      S_PC_TURN: begin
        if (shot_valid) begin
          if (shot_hit && (r_playerCells != 4'd0)) begin
            w_playerCells = r_playerCells - 4'd1;
            w_nextState   = (r_playerCells == 4'd1) ? S_LOSE : S_PLAYER_TURN;
          end else begin
            w_nextState = S_PLAYER_TURN;
          end
        end
      end

      S_WIN, S_LOSE: begin
        if (w_startEdge) begin
          w_nextState = S_IDLE;
        end
      end

      default: w_nextState = S_IDLE;
    endcase
  end

  // State and datapath registers. The edge-detect history registers track
  // their inputs every cycle regardless of state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_startPrev   <= 1'b0;
      r_confirmPrev <= 1'b0;
      r_shipCount   <= 3'd0;
      r_playerCells <= 4'd0;
      r_pcCells     <= 4'd0;
`ifdef TURN_TIMER_EN
      r_turnCnt     <= '0;
      r_turnTimeout <= 1'b0;
`endif
    end else begin
      r_state       <= w_nextState;
      r_startPrev   <= start_btn;
      r_confirmPrev <= confirm_placement;
      r_shipCount   <= w_shipCount;
      r_playerCells <= w_playerCells;
      r_pcCells     <= w_pcCells;
`ifdef TURN_TIMER_EN
      r_turnCnt     <= w_turnCnt;
      r_turnTimeout <= w_turnTimeout;
`endif
    end
  end

  assign colocation_ships_State = (r_state == S_PLACE);
  assign pc_place_req           = (r_state == S_PC_PLACE);
  assign player_turn            = (r_state == S_PLAYER_TURN);
  assign pc_turn                = (r_state == S_PC_TURN);
  assign game_won               = (r_state == S_WIN);
  assign game_lost              = (r_state == S_LOSE);
  assign initial_ships_count    = r_shipCount;
  assign player_cells_left      = r_playerCells;
  assign pc_cells_left          = r_pcCells;

`ifdef TURN_TIMER_EN
  assign turn_timeout = r_turnTimeout;
`else
  assign turn_timeout = 1'b0;
`endif

endmodule

// File: doc/battleship_game_fsm.md
# battleship_game_fsm

Top-level game sequencer for the battleship VGA design. It enables the ship-placement datapath one ship length at a time and hands off to the PC board generator. It then alternates player and PC turns, with an optional per-turn timeout, and tracks the unsunk cells on both boards to declare win or loss.

## Interface
Parameters:
- TURN_CYCLES, 750_000_000, player-turn timeout length in clk cycles (15 s at 50 MHz); counter width $clog2(TURN_CYCLES).
- MAX_SHIPS, 5, largest ship length and maximum ship count; board is 5x5.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- start_btn  in  1  level; rising edge starts or restarts the game.
- ships_to_place  in  3  ship count n, sampled on the start edge in IDLE; clamped to 1..MAX_SHIPS.
- confirm_placement  in  1  level from the placement block; a rising edge means one ship was placed.
- placement_error  in  1  level from the placement block; confirm edges are ignored while it is high.
- pc_place_done  in  1  single-cycle pulse; PC board generation is finished.
- shot_valid  in  1  single-cycle pulse; the current side's shot is resolved.
- shot_hit  in  1  qualifies shot_valid: 1 means hit.
- colocation_ships_State  out  1  high in PLACE.
- initial_ships_count  out  3  length of the ship currently being placed.
- pc_place_req  out  1  high in PC_PLACE.
- player_turn  out  1  high in PLAYER_TURN.
- pc_turn  out  1  high in PC_TURN.
- game_won  out  1  high in WIN.
- game_lost  out  1  high in LOSE.
- turn_timeout  out  1  single-cycle pulse when the player forfeits a turn.
- player_cells_left  out  4  unsunk cells on the player board.
- pc_cells_left  out  4  unsunk cells on the PC board.

## Operation
- Moore FSM with states IDLE, PLACE, PC_PLACE, PLAYER_TURN, PC_TURN, WIN, LOSE.
- Reset values: state IDLE, all outputs 0, internal edge registers 0.
- Edge detection on start_btn and confirm_placement uses a registered previous value; the prev registers update every cycle in every state.
- IDLE, start edge:
  - latch n = clamp(ships_to_place); 0 becomes 1, values above MAX_SHIPS become MAX_SHIPS.
  - initial_ships_count := n; both cells_left := n(n+1)/2 (max 15, fits 4 bits).
  - go to PLACE.
- PLACE, confirm edge with placement_error low:
  - if initial_ships_count > 1, decrement it.
  - if it equals 1, set it to 0 and go to PC_PLACE.
- PLACE, confirm edge with placement_error high: no change.
- PC_PLACE: hold pc_place_req; go to PLAYER_TURN on pc_place_done.
- PLAYER_TURN, shot_valid:
  - on a hit, decrement pc_cells_left; go to WIN if the pre-decrement value was 1, otherwise to PC_TURN.
  - on a miss, go to PC_TURN.
- PC_TURN, shot_valid: same rule applied to player_cells_left; reaching 0 goes to LOSE, otherwise to PLAYER_TURN.
- cells_left never underflows; a hit while the count is already 0 is ignored.
- WIN/LOSE: hold; a start edge goes to IDLE, and a second start edge starts a new game.
- start edge outside IDLE/WIN/LOSE: ignored.
- shot_valid outside the turn states: ignored.
- pc_place_done outside PC_PLACE: ignored.

## Timing
- Inputs are sampled at posedge N; state and outputs change at posedge N+1 (1-cycle latency).
- A confirm level held high produces exactly one decrement.
- Turn counter (when compiled in):
  - clears on every entry to PLAYER_TURN and counts while in that state.
  - when it reaches TURN_CYCLES-1 with no shot_valid, turn_timeout pulses for 1 cycle coincident with the PLAYER_TURN to PC_TURN transition.
- shot_valid in the same cycle as the terminal count: the shot wins and no timeout is raised.
- rst low at any posedge returns every state, counter and output to its reset value on that edge, regardless of state.

## Configuration
- TURN_TIMER_EN defined: turn counter and timeout behaviour as above.
- TURN_TIMER_EN undefined: no counter is synthesized; turn_timeout is tied to 0 and PLAYER_TURN waits indefinitely for shot_valid.

## Test plan
- Reset, then start edge with ships_to_place=3 -> PLACE, initial_ships_count=3, both cells_left=6.
- Three clean confirm edges, then placement_error=1 with a confirm edge, per the ordering below:
  - first two clean edges -> count 3, 2, 1.
  - error-high edge while count=1 -> no change.
  - third clean edge -> count 0, then PC_PLACE; pc_place_done -> PLAYER_TURN.
- ships_to_place=0 -> initial_ships_count=1, cells_left=1; one player hit -> game_won next cycle.
- ships_to_place=7 -> clamped to 5, cells_left=15.
- TURN_TIMER_EN with TURN_CYCLES=10 and no shot:
  - turn_timeout pulses exactly 10 cycles after entering PLAYER_TURN, with pc_turn high the same cycle.
  - shot_valid at cycle 10 -> no timeout.
- In PC_TURN with player_cells_left=1, shot_valid with hit -> LOSE; start edge -> IDLE; rst low mid-PLAYER_TURN -> all outputs 0 next edge.
